afu_tlx_cmd_responder: RTL and testbench
========================================

AFU_TLX_CMD_RESPONDER -- requirements
Module: afu_tlx_cmd_responder

Interface
REQ-001 SHALL have parameter CMD_DEPTH, default 4: command FIFO entries, equal to command credits advertised to TLX.
REQ-002 SHALL have parameter RESP_CREDITS, default 8: initial AFU->TLX response credits.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 ha_pclock  in  1  sole clock, all logic on rising edge.
REQ-005 ha_preset  in  1  synchronous active-high reset.
REQ-006 tlx_afu_cmd_valid  in  1  one-cycle command strobe from TLX.
REQ-007 tlx_afu_cmd_opcode  in  8  command opcode.
REQ-008 tlx_afu_cmd_capptag  in  16  command tag, echoed in response.
REQ-009 tlx_afu_cmd_dl  in  2  data length, echoed in response.
REQ-010 tlx_afu_resp_credit  in  1  one-cycle pulse, TLX returns one response credit.
REQ-011 afu_tlx_cmd_initial_credit  out  7  constant CMD_DEPTH.
REQ-012 afu_tlx_cmd_credit  out  1  one-cycle pulse, one command credit returned.
REQ-013 afu_tlx_resp_valid  out  1  one-cycle response strobe.
REQ-014 afu_tlx_resp_opcode  out  8  response opcode.
REQ-015 afu_tlx_resp_capptag  out  16  echoed capptag.
REQ-016 afu_tlx_resp_dl  out  2  echoed dl.
REQ-017 afu_tlx_resp_code  out  4  fail code, 0 on success.
REQ-018 protocol_error  out  1  sticky error flag.

Function
REQ-019 SHALL push {opcode, capptag, dl} into the FIFO on each cycle tlx_afu_cmd_valid=1 and occupancy<CMD_DEPTH at start of cycle.
REQ-020 SHALL drop a command arriving with occupancy==CMD_DEPTH at start of cycle, even if a pop occurs that cycle, and set protocol_error.
REQ-021 SHALL pop the FIFO head and issue a response in the same cycle when FIFO non-empty and response credit count>0; at most one response per cycle.
REQ-022 Latency: command pushed at edge N to empty FIFO with credits available SHALL produce afu_tlx_resp_valid=1 in cycle after edge N+1 (one-cycle registered path).
REQ-023 Opcode map: 0x20 (rd_mem) -> resp 0x01 code 0; 0x81 (write_mem) -> resp 0x04 code 0; any other -> resp 0x05 code 0xE.
REQ-024 SHALL hold resp opcode/capptag/dl/code at last issued value when resp_valid=0.
REQ-025 SHALL pulse afu_tlx_cmd_credit for exactly one cycle, coincident with each afu_tlx_resp_valid pulse.
REQ-026 Response credit counter: init RESP_CREDITS; -1 on response issue; +1 on tlx_afu_resp_credit; both same cycle -> unchanged.
REQ-027 Credit return with counter==RESP_CREDITS and no issue that cycle SHALL leave counter at RESP_CREDITS and set protocol_error.
REQ-028 Counter==0 SHALL stall responses; FIFO continues accepting up to CMD_DEPTH.
REQ-029 FIFO read/write pointers SHALL wrap modulo CMD_DEPTH; responses SHALL be issued in arrival order.
REQ-030 Simultaneous push and pop with 0<occupancy<CMD_DEPTH SHALL leave occupancy unchanged.
REQ-031 protocol_error SHALL remain 1 until reset.

Reset
REQ-032 While ha_preset=1: FIFO empty, pointers 0, credit counter=RESP_CREDITS, afu_tlx_resp_valid=0, afu_tlx_cmd_credit=0, resp opcode/capptag/dl/code=0, protocol_error=0.
REQ-033 Commands and credit pulses during reset SHALL be ignored; in-flight FIFO contents SHALL be discarded without responses or credit pulses.
REQ-034 afu_tlx_cmd_initial_credit SHALL equal CMD_DEPTH at all times, including reset.

Verification
REQ-035 Single rd_mem, opcode 0x20 capptag 0x1234 dl 1 -> next cycle resp_valid, opcode 0x01, capptag 0x1234, dl 1, code 0, cmd_credit pulse.
REQ-036 Opcode 0x55 capptag 0x0007 -> resp 0x05, code 0xE, capptag 0x0007.
REQ-037 RESP_CREDITS=2, 4 back-to-back commands, no returns -> exactly 2 responses, stall; two resp_credit pulses -> remaining 2 in order.
REQ-038 5 commands with credits withheld, CMD_DEPTH=4 -> 5th dropped, protocol_error=1; after credits, 4 responses only.
REQ-039 resp_credit pulse at counter==RESP_CREDITS, idle -> protocol_error=1, counter stays 8; resp_credit coincident with issue at counter 8 -> no error.
REQ-040 Reset asserted with 3 queued commands -> no responses afterward, protocol_error=0, new command answered at normal latency.

Source files
------------

// File: rtl/afu_tlx_cmd_responder_if.sv
// TLX <-> AFU command/response bus: commands and response credits flow in,
// responses, command credits and the initial credit advertisement flow out.
interface afu_tlx_cmd_responder_if;
    logic        tlx_afu_cmd_valid;
    logic [7:0]  tlx_afu_cmd_opcode;
    logic [15:0] tlx_afu_cmd_capptag;
    logic [1:0]  tlx_afu_cmd_dl;
    logic        tlx_afu_resp_credit;
    logic [6:0]  afu_tlx_cmd_initial_credit;
    logic        afu_tlx_cmd_credit;
    logic        afu_tlx_resp_valid;
    logic [7:0]  afu_tlx_resp_opcode;
    logic [15:0] afu_tlx_resp_capptag;
    logic [1:0]  afu_tlx_resp_dl;
    logic [3:0]  afu_tlx_resp_code;

    // TLX side drives commands and returns response credits
    modport master (
        output tlx_afu_cmd_valid, tlx_afu_cmd_opcode, tlx_afu_cmd_capptag,
               tlx_afu_cmd_dl, tlx_afu_resp_credit,
        input  afu_tlx_cmd_initial_credit, afu_tlx_cmd_credit, afu_tlx_resp_valid,
               afu_tlx_resp_opcode, afu_tlx_resp_capptag, afu_tlx_resp_dl,
               afu_tlx_resp_code
    );

    modport slave (
        input  tlx_afu_cmd_valid, tlx_afu_cmd_opcode, tlx_afu_cmd_capptag,
               tlx_afu_cmd_dl, tlx_afu_resp_credit,
        output afu_tlx_cmd_initial_credit, afu_tlx_cmd_credit, afu_tlx_resp_valid,
               afu_tlx_resp_opcode, afu_tlx_resp_capptag, afu_tlx_resp_dl,
               afu_tlx_resp_code
    );
endinterface

// File: rtl/afu_tlx_cmd_responder.sv
// Queues TLX commands in a credit-sized FIFO and answers them in order, one per
// cycle, as long as AFU->TLX response credits remain.
module afu_tlx_cmd_responder #(
    parameter int CMD_DEPTH    = 4,
    parameter int RESP_CREDITS = 8
) (
    input  logic                   ha_pclock,
    input  logic                   ha_preset,
    afu_tlx_cmd_responder_if.slave tlx,
    output logic                   protocol_error
);

    localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CNT_W = $clog2(CMD_DEPTH + 1);
    localparam int CRD_W = $clog2(RESP_CREDITS + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(CMD_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CMD_DEPTH);
    localparam logic [CRD_W-1:0] MAX_CRD  = CRD_W'(RESP_CREDITS);

    typedef struct packed {
        logic [7:0]  opcode;
        logic [15:0] capptag;
        logic [1:0]  dl;
    } cmdEntry_t;

    cmdEntry_t        fifoMem [CMD_DEPTH];
    cmdEntry_t        headEntry;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] cmdCount;
    logic [CRD_W-1:0] respCredits;
    logic             doPush;
    logic             doPop;
    logic             dropCmd;
    logic             creditOverflow;
    logic [11:0]      mappedResp;

    logic             respVld_p1;
    logic             cmdCredit_p1;
    logic [7:0]       respOpcode_p1;
    logic [15:0]      respCapptag_p1;
    logic [1:0]       respDl_p1;
    logic [3:0]       respCode_p1;

    // Returns {response opcode, fail code}
    function automatic logic [11:0] mapResp(input logic [7:0] cmdOpcode);
        case (cmdOpcode)
            8'h20:   return {8'h01, 4'h0};
            8'h81:   return {8'h04, 4'h0};
            default: return {8'h05, 4'hE};
        endcase
    endfunction

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    // Acceptance looks only at start-of-cycle occupancy, so a same-cycle pop
    // never rescues a command that arrives to a full FIFO.
    assign doPush         = tlx.tlx_afu_cmd_valid && (cmdCount != FULL_CNT);
    assign dropCmd        = tlx.tlx_afu_cmd_valid && (cmdCount == FULL_CNT);
    assign doPop          = (cmdCount != '0) && (respCredits != '0);
    assign creditOverflow = tlx.tlx_afu_resp_credit && !doPop && (respCredits == MAX_CRD);
    assign headEntry      = fifoMem[rdPtr];
    assign mappedResp     = mapResp(headEntry.opcode);

    always_ff @(posedge ha_pclock) begin
        if (doPush) begin
            fifoMem[wrPtr] <= '{opcode:  tlx.tlx_afu_cmd_opcode,
                                capptag: tlx.tlx_afu_cmd_capptag,
                                dl:      tlx.tlx_afu_cmd_dl};
        end
    end

    // p0 -> p1: FIFO head is popped and the response registered in one step
    always_ff @(posedge ha_pclock) begin
        if (ha_preset) begin
            wrPtr          <= '0;
            rdPtr          <= '0;
            cmdCount       <= '0;
            respCredits    <= MAX_CRD;
            protocol_error <= 1'b0;
            respVld_p1     <= 1'b0;
            cmdCredit_p1   <= 1'b0;
            respOpcode_p1  <= '0;
            respCapptag_p1 <= '0;
            respDl_p1      <= '0;
            respCode_p1    <= '0;
        end else begin
            if (doPush) wrPtr <= nextPtr(wrPtr);
            if (doPop)  rdPtr <= nextPtr(rdPtr);
            case ({doPush, doPop})
                2'b10:   cmdCount <= cmdCount + 1'b1;
                2'b01:   cmdCount <= cmdCount - 1'b1;
                default: ;
            endcase
            case ({doPop, tlx.tlx_afu_resp_credit})
                2'b10:   respCredits <= respCredits - 1'b1;
                2'b01:   if (respCredits != MAX_CRD) respCredits <= respCredits + 1'b1;
                default: ;
            endcase
            if (dropCmd || creditOverflow) protocol_error <= 1'b1;
            respVld_p1   <= doPop;
            cmdCredit_p1 <= doPop;
            if (doPop) begin
                respOpcode_p1  <= mappedResp[11:4];
                respCode_p1    <= mappedResp[3:0];
                respCapptag_p1 <= headEntry.capptag;
                respDl_p1      <= headEntry.dl;
            end
        end
    end

    assign tlx.afu_tlx_cmd_initial_credit = 7'(CMD_DEPTH);
    assign tlx.afu_tlx_cmd_credit         = cmdCredit_p1;
    assign tlx.afu_tlx_resp_valid         = respVld_p1;
    assign tlx.afu_tlx_resp_opcode        = respOpcode_p1;
    assign tlx.afu_tlx_resp_capptag       = respCapptag_p1;
    assign tlx.afu_tlx_resp_dl            = respDl_p1;
    assign tlx.afu_tlx_resp_code          = respCode_p1;

endmodule

// File: tb/tb_afu_tlx_cmd_responder.sv
// Randomized and directed bench for afu_tlx_cmd_responder with a queue-based
// reference model and a scoreboard monitor sampling on the falling edge.
module tb_afu_tlx_cmd_responder;

    localparam int CMD_DEPTH    = 4;
    localparam int RESP_CREDITS = 8;

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] tag;
        logic [1:0]  dl;
    } cmd_t;

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] tag;
        logic [1:0]  dl;
        logic [3:0]  code;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic protocolError;

    afu_tlx_cmd_responder_if bus ();

    afu_tlx_cmd_responder #(
        .CMD_DEPTH    (CMD_DEPTH),
        .RESP_CREDITS (RESP_CREDITS)
    ) dut (
        .ha_pclock      (clk),
        .ha_preset      (rst),
        .tlx            (bus.slave),
        .protocol_error (protocolError)
    );

    always #5 clk = ~clk;

    int   nChecks = 0;
    int   nFail   = 0;
    bit   monOn   = 1'b0;

    cmd_t pendQ[$];
    rsp_t expQ[$];
    int   mCred = RESP_CREDITS;
    bit   mErr  = 1'b0;
    bit   expVld = 1'b0;
    rsp_t lastRsp = '0;

    int   occ;
    bit   issue;
    cmd_t headCmd;
    rsp_t got;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rsp_t respFor(input cmd_t c);
        rsp_t r;
        r.tag = c.tag;
        r.dl  = c.dl;
        if (c.op == 8'h20)      begin r.op = 8'h01; r.code = 4'h0; end
        else if (c.op == 8'h81) begin r.op = 8'h04; r.code = 4'h0; end
        else                    begin r.op = 8'h05; r.code = 4'hE; end
        return r;
    endfunction

    // Reference model: queue of pending commands plus a credit count.
    always @(posedge clk) begin
        if (rst) begin
            pendQ.delete();
            expQ.delete();
            mCred   = RESP_CREDITS;
            mErr    = 1'b0;
            expVld  = 1'b0;
            lastRsp = '0;
        end else begin
            occ    = pendQ.size();
            issue  = (occ > 0) && (mCred > 0);
            expVld = issue;
            if (issue) begin
                headCmd = pendQ.pop_front();
                lastRsp = respFor(headCmd);
                expQ.push_back(lastRsp);
            end
            if (bus.tlx_afu_cmd_valid) begin
                if (occ < CMD_DEPTH)
                    pendQ.push_back('{op: bus.tlx_afu_cmd_opcode, tag: bus.tlx_afu_cmd_capptag,
                                      dl: bus.tlx_afu_cmd_dl});
                else
                    mErr = 1'b1;
            end
            mCred = mCred - (issue ? 1 : 0) + (bus.tlx_afu_resp_credit ? 1 : 0);
            if (mCred > RESP_CREDITS) begin
                mCred = RESP_CREDITS;
                mErr  = 1'b1;
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (monOn) begin
            chk("initial_credit", 32'(bus.afu_tlx_cmd_initial_credit), CMD_DEPTH);
            chk("resp_valid", 32'(bus.afu_tlx_resp_valid), 32'(expVld));
            chk("cmd_credit", 32'(bus.afu_tlx_cmd_credit), 32'(expVld));
            chk("protocol_error", 32'(protocolError), 32'(mErr));
            if (bus.afu_tlx_resp_valid === 1'b1) begin
                if (expQ.size() == 0) begin
                    chk("unexpected_resp", 32'(expQ.size()), 1);
                end else begin
                    got = expQ.pop_front();
                    chk("resp_opcode",  32'(bus.afu_tlx_resp_opcode),  32'(got.op));
                    chk("resp_capptag", 32'(bus.afu_tlx_resp_capptag), 32'(got.tag));
                    chk("resp_dl",      32'(bus.afu_tlx_resp_dl),      32'(got.dl));
                    chk("resp_code",    32'(bus.afu_tlx_resp_code),    32'(got.code));
                end
            end else begin
                chk("hold_opcode",  32'(bus.afu_tlx_resp_opcode),  32'(lastRsp.op));
                chk("hold_capptag", 32'(bus.afu_tlx_resp_capptag), 32'(lastRsp.tag));
                chk("hold_dl",      32'(bus.afu_tlx_resp_dl),      32'(lastRsp.dl));
                chk("hold_code",    32'(bus.afu_tlx_resp_code),    32'(lastRsp.code));
            end
        end
    end

    task automatic cyc(input bit v, input logic [7:0] op, input logic [15:0] tag,
                       input logic [1:0] dl, input bit cr);
        @(negedge clk);
        bus.tlx_afu_cmd_valid   = v;
        bus.tlx_afu_cmd_opcode  = op;
        bus.tlx_afu_cmd_capptag = tag;
        bus.tlx_afu_cmd_dl      = dl;
        bus.tlx_afu_resp_credit = cr;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'h00, 16'h0000, 2'd0, 1'b0);
    endtask

    task automatic credit();
        cyc(1'b0, 8'h00, 16'h0000, 2'd0, 1'b1);
    endtask

    task automatic doReset(input int n);
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b1, 8'h20, 16'hDEAD, 2'd1, 1'b1);
        idle(n);
        rst = 1'b0;
    endtask

    initial begin
        bus.tlx_afu_cmd_valid   = 1'b0;
        bus.tlx_afu_cmd_opcode  = '0;
        bus.tlx_afu_cmd_capptag = '0;
        bus.tlx_afu_cmd_dl      = '0;
        bus.tlx_afu_resp_credit = 1'b0;
        repeat (2) @(negedge clk);
        monOn = 1'b1;
        idle(2);
        rst = 1'b0;

        // Single commands of each opcode class
        cyc(1'b1, 8'h20, 16'h1234, 2'd1, 1'b0); idle(3);
        cyc(1'b1, 8'h55, 16'h0007, 2'd0, 1'b0); idle(3);
        cyc(1'b1, 8'h81, 16'hABCD, 2'd3, 1'b0); idle(3);

        // Use up the remaining credits, then stall with queued commands
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h20, 16'(16'h0040 + i), 2'(i), 1'b0);
        idle(3);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'h81, 16'(16'h0100 + i), 2'(i), 1'b0);
        idle(4);
        for (int i = 0; i < 4; i++) begin credit(); idle(2); end

        // Overfill: fifth command is dropped and flags an error
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h30 + i), 16'(16'h0200 + i), 2'(i), 1'b0);
        idle(3);
        for (int i = 0; i < 6; i++) begin credit(); idle(1); end
        idle(3);

        // Credit return with a full counter and nothing issuing
        doReset(1);
        idle(2);
        credit(); idle(3);

        // Credit return coincident with an issue at a full counter
        doReset(1);
        idle(1);
        cyc(1'b1, 8'h20, 16'h0555, 2'd2, 1'b0);
        credit(); idle(3);

        // Reset while commands are queued behind exhausted credits
        for (int i = 0; i < 11; i++) cyc(1'b1, 8'h81, 16'(16'h0300 + i), 2'(i), 1'b0);
        idle(2);
        doReset(2);
        idle(3);
        cyc(1'b1, 8'h20, 16'hBEEF, 2'd2, 1'b0); idle(3);

        // Randomized traffic that stays within the protocol
        doReset(1);
        for (int i = 0; i < 400; i++) begin
            bit   v;
            bit   cr;
            logic [7:0] op;
            int   sel;
            v   = ($urandom_range(0, 2) != 0) && (pendQ.size() < CMD_DEPTH);
            cr  = (mCred < RESP_CREDITS) && ($urandom_range(0, 2) == 0);
            sel = $urandom_range(0, 3);
            op  = (sel == 0) ? 8'h20 : (sel == 1) ? 8'h81 : 8'($urandom);
            cyc(v, op, 16'($urandom), 2'($urandom), cr);
        end
        for (int i = 0; i < 100 && pendQ.size() > 0; i++)
            cyc(1'b0, 8'h00, 16'h0000, 2'd0, mCred < RESP_CREDITS);
        idle(3);
        chk("drain_pending", 32'(pendQ.size()), 0);
        chk("scoreboard_empty", 32'(expQ.size()), 0);

        monOn = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
